sd_cmd_phy: RTL and testbench
=============================

# sd_cmd_phy

Serial command-line engine for the SD host, directly downstream of the command master. It accepts a 40-bit command frame and a settings word through a two-flop-synchronised req/ack handshake, and appends CRC7 and the end bit. It then drives the 48-bit frame onto the SD CMD line, optionally captures the card response, and returns the response plus a status byte to the master through a second req/ack handshake.

## Interface
Parameters:
- `WAIT_START_MAX`, default 64: clocks to wait for the response start bit before declaring a timeout.

Ports:
- `clk` in 1: single clock; one CMD bit is shifted per `clk`.
- `rst` in 1: reset, asynchronous and active-high.
- `cmd_in` in 40: command frame `{2'b01, index[5:0], arg[31:0]}`.
- `settings_in` in 16: settings word. [12] read, [11] write, [10:8] turnaround delay, [7] CRC check, [6:0] response size.
- `req_in` in 1: new command request (asynchronous domain, synchronised internally).
- `ack_in` in 1: master's acknowledge of presented status (synchronised internally).
- `go_idle` in 1: abort.
- `req_out` out 1: status/response available.
- `ack_out` out 1: ready / command accepted.
- `cmd_out` out 40: captured response bits.
- `status` out 8: [7] busy, [6] response done, [5] crc_ok, [4] timeout, [3:0] 0.
- `cmd_o` out 1: CMD line output data.
- `cmd_oe` out 1: CMD line output enable.
- `cmd_i` in 1: CMD line input.

## Operation
- Reset values:
  - `req_out`=0, `ack_out`=0, `cmd_out`=0, `status`=0, `cmd_o`=1, `cmd_oe`=0.
  - State IDLE; all counters 0.
- `req_in`/`ack_in` each pass through a 2-FF synchroniser (`req_s`, `ack_s`) before use.
- States:
  - **IDLE**: `ack_out`=1, `req_out`=0, `cmd_oe`=0.
    - `req_s`=1 → latch `cmd_in`/`settings_in`, clear `status`, set `status[7]`, `ack_out`=0 → WRITE.
  - **WRITE**: `cmd_oe`=1; shift 40 frame bits MSB first; CRC7 (x^7+x^3+1, init 0) accumulates over these 40 bits.
    - Then 7 CRC bits MSB first, then end bit 1: 48 bits total.
    - → DELAY.
  - **DELAY**: `cmd_oe`=0, `cmd_o`=1 for `settings[10:8]`+1 clocks.
    - Response size 0 → FINISH with `status[6]`=1, `status[5]`=1.
    - Otherwise → WAIT_START.
  - **WAIT_START**: sample `cmd_i` each clock.
    - `cmd_i`=0 → READ; the start bit is counted as bit 0.
    - `WAIT_START_MAX` clocks without `cmd_i`=0 → FINISH with `status[4]`=1, `status[6]`=0.
  - **READ**: shift `cmd_i` into `cmd_out` MSB first (shift-left, new bit at [0]).
    - Size 40 (short): 48 bits total. Bits 0..39 → `cmd_out`, bits 40..46 compared against CRC7 of bits 0..39, bit 47 is the end bit.
    - Size 127 (long): 136 bits total. `cmd_out` holds the last 40 bits shifted in before the final 8; CRC not checked, `crc_ok`=1.
    - Any other nonzero size is treated as short.
    - → FINISH with `status[6]`=1, `status[5]` = CRC match (forced 1 when `settings[7]`=0).
  - **FINISH**: `status[7]`=0, `req_out`=1 until `ack_s`=1. Then `req_out`=0, and wait for `ack_s`=0 and `req_s`=0 → IDLE.
- `go_idle`=1 in any state → IDLE next clock:
  - `cmd_oe`=0, `req_out`=0, `status` cleared, `cmd_out` unchanged.
  - `go_idle` has priority over all transitions.
- `req_s` asserted outside IDLE is ignored; it is only acted on in IDLE.

## Timing
- `req_in` rising at edge N → `req_s` high at N+2 → latch and enter WRITE at N+3.
- First `cmd_o`=0 (start bit) with `cmd_oe`=1 at N+4.
- Last bit (end bit) at N+51.
- DELAY lasts exactly `settings[10:8]`+1 clocks after the end bit.
- Response completion: `req_out` rises one clock after the end-bit sample.
- `ack_out` falls the same clock WRITE is entered and rises on return to IDLE.
- The CRC register and the bit counter (8-bit, width for 136) clear on entry to WRITE and READ; no wrap occurs.

## Configuration
- `SD_CMD_CRC_CHECK_EN` defined: the receive CRC7 checker is compiled in and `status[5]` reflects the comparison for short responses.
- Undefined: the checker is removed and `status[5]` is constant 1 whenever `status[6]`=1. Transmit CRC is always present.

## Test plan
- CMD0 (`cmd_in`=40'h4000000000), size 0, delay 3: `cmd_o` carries 48'h400000000095; `req_out` after 4 idle clocks; `status`=8'h60.
- CMD8 arg 32'h1AA, size 40: card replies 48'h08000001AA13 → `cmd_out`=40'h08000001AA, `status`=8'h60.
- Same reply with corrupted CRC byte, `settings[7]`=1 → `status`=8'h40. Macro undefined → 8'h60.
- `cmd_i` held 1, size 40: after 64 clocks in WAIT_START → `status`=8'h10, `req_out`=1.
- Size 127, 136-bit reply streamed: `status[6]`=1, `cmd_out` equals bits 88..127 of the stream.
- `go_idle` pulsed mid-WRITE (bit 20): next clock `cmd_oe`=0, `ack_out`=1; a new `req_in` is then accepted normally.

Source files
------------

// File: rtl/sd_cmd_phy.sv
// rtl/sd_cmd_phy.sv - SD CMD line engine: framed command out with CRC7, optional response capture (SD_CMD_CRC_CHECK_EN enables receive CRC check)
module sd_cmd_phy #(
    parameter int WAIT_START_MAX = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] cmd_in,
    input  logic [15:0] settings_in,
    input  logic        req_in,
    input  logic        ack_in,
    input  logic        go_idle,
    output logic        req_out,
    output logic        ack_out,
    output logic [39:0] cmd_out,
    output logic [7:0]  status,
    output logic        cmd_o,
    output logic        cmd_oe,
    input  logic        cmd_i
);
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_DELAY, S_WAIT_START, S_READ, S_FINISH, S_ACK_WAIT
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_START_MAX - 1);

    state_t      state, state_nxt;
    logic        req_meta, req_s, ack_meta, ack_s;
    logic [7:0]  cnt;
    logic [39:0] tx_sh;
    logic [6:0]  crc;
    logic [2:0]  delay;
    logic [6:0]  rsp_size;
    logic        rsp_long;
    logic [7:0]  read_last;
    logic [7:0]  shift_lim;
    logic        crc_ok;

    // One CRC7 (x^7 + x^3 + 1) step for a single serial bit
    function automatic logic [6:0] crc_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    assign rsp_long  = (rsp_size == 7'd127);
    assign read_last = rsp_long ? 8'd135 : 8'd47;
    assign shift_lim = rsp_long ? 8'd128 : 8'd40;

`ifdef SD_CMD_CRC_CHECK_EN
    logic [6:0] rx_crc;
    logic       crc_chk;
    logic       unused_ok;
    assign unused_ok = &{1'b0, settings_in[15:11]};
    assign crc_ok    = rsp_long || !crc_chk || (rx_crc == crc);
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, settings_in[15:11], settings_in[7]};
    assign crc_ok    = 1'b1;
`endif

    // Two-flop synchronisers for the master handshake lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_meta <= 1'b0;
            req_s    <= 1'b0;
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            req_meta <= req_in;
            req_s    <= req_meta;
            ack_meta <= ack_in;
            ack_s    <= ack_meta;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; abort overrides every transition
    always_comb begin
        state_nxt = state;
        if (go_idle) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:       if (req_s) state_nxt = S_WRITE;
                S_WRITE:      if (cnt == 8'd47) state_nxt = S_DELAY;
                S_DELAY:      if (cnt == {5'd0, delay})
                                  state_nxt = (rsp_size == 7'd0) ? S_FINISH : S_WAIT_START;
                S_WAIT_START: if (!cmd_i) state_nxt = S_READ;
                              else if (cnt == WAIT_LAST) state_nxt = S_FINISH;
                S_READ:       if (cnt == read_last) state_nxt = S_FINISH;
                S_FINISH:     if (ack_s) state_nxt = S_ACK_WAIT;
                S_ACK_WAIT:   if (!ack_s && !req_s) state_nxt = S_IDLE;
                default:      state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath: serialiser, CRC, response capture, status and handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_out  <= 1'b0;
            ack_out  <= 1'b0;
            cmd_out  <= '0;
            status   <= '0;
            cmd_o    <= 1'b1;
            cmd_oe   <= 1'b0;
            cnt      <= '0;
            tx_sh    <= '0;
            crc      <= '0;
            delay    <= '0;
            rsp_size <= '0;
`ifdef SD_CMD_CRC_CHECK_EN
            rx_crc   <= '0;
            crc_chk  <= 1'b0;
`endif
        end else if (go_idle) begin
            req_out <= 1'b0;
            ack_out <= 1'b1;
            status  <= '0;
            cmd_o   <= 1'b1;
            cmd_oe  <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cmd_o   <= 1'b1;
                    cmd_oe  <= 1'b0;
                    req_out <= 1'b0;
                    ack_out <= 1'b1;
                    cnt     <= '0;
                    if (req_s) begin
                        tx_sh    <= cmd_in;
                        delay    <= settings_in[10:8];
                        rsp_size <= settings_in[6:0];
`ifdef SD_CMD_CRC_CHECK_EN
                        crc_chk  <= settings_in[7];
`endif
                        crc      <= '0;
                        status   <= 8'h80;
                        ack_out  <= 1'b0;
                    end
                end
                S_WRITE: begin
                    cmd_oe <= 1'b1;
                    cnt    <= cnt + 8'd1;
                    if (cnt < 8'd40) begin
                        cmd_o <= tx_sh[39];
                        tx_sh <= {tx_sh[38:0], 1'b0};
                        crc   <= crc_step(crc, tx_sh[39]);
                    end else if (cnt < 8'd47) begin
                        cmd_o <= crc[6];
                        crc   <= {crc[5:0], 1'b0};
                    end else begin
                        cmd_o <= 1'b1;
                        cnt   <= '0;
                    end
                end
                S_DELAY: begin
                    cmd_oe <= 1'b0;
                    cmd_o  <= 1'b1;
                    crc    <= '0;
                    cnt    <= cnt + 8'd1;
                    if (cnt == {5'd0, delay}) begin
                        cnt <= '0;
                        if (rsp_size == 7'd0) status <= 8'h60;
                    end
                end
                S_WAIT_START: begin
                    cnt <= cnt + 8'd1;
                    if (!cmd_i) begin
                        // The start bit is response bit 0
                        cnt     <= 8'd1;
                        cmd_out <= {cmd_out[38:0], cmd_i};
                        crc     <= crc_step(crc, cmd_i);
                    end else if (cnt == WAIT_LAST) begin
                        status <= 8'h10;
                    end
                end
                S_READ: begin
                    cnt <= cnt + 8'd1;
                    if (cnt < shift_lim) cmd_out <= {cmd_out[38:0], cmd_i};
                    if (cnt < 8'd40)     crc <= crc_step(crc, cmd_i);
`ifdef SD_CMD_CRC_CHECK_EN
                    if (cnt >= 8'd40 && cnt < 8'd47) rx_crc <= {rx_crc[5:0], cmd_i};
`endif
                    if (cnt == read_last) begin
                        cnt    <= '0;
                        status <= {1'b0, 1'b1, crc_ok, 5'd0};
                    end
                end
                S_FINISH: begin
                    cmd_oe  <= 1'b0;
                    cmd_o   <= 1'b1;
                    req_out <= !ack_s;
                end
                S_ACK_WAIT: begin
                    req_out <= 1'b0;
                    if (!ack_s && !req_s) ack_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_cmd_phy.sv
// tb/tb_sd_cmd_phy.sv - self-checking bench for sd_cmd_phy
module tb_sd_cmd_phy;
    logic        clk, rst;
    logic [39:0] cmd_in;
    logic [15:0] settings_in;
    logic        req_in, ack_in, go_idle;
    logic        req_out, ack_out;
    logic [39:0] cmd_out;
    logic [7:0]  status;
    logic        cmd_o, cmd_oe, cmd_i;

    sd_cmd_phy #(.WAIT_START_MAX(64)) dut (
        .clk(clk), .rst(rst), .cmd_in(cmd_in), .settings_in(settings_in),
        .req_in(req_in), .ack_in(ack_in), .go_idle(go_idle),
        .req_out(req_out), .ack_out(ack_out), .cmd_out(cmd_out), .status(status),
        .cmd_o(cmd_o), .cmd_oe(cmd_oe), .cmd_i(cmd_i)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Model state for the command in flight
    logic        active = 1'b0;
    int          tx_start = 0;
    int          tx_delay = 0;
    int          req_cyc = 0;
    int          abort_cyc = 1 << 30;
    logic [47:0] tx_frame = '0;
    logic [7:0]  exp_status = '0;
    logic [39:0] exp_out = '0;
    logic        chk_out = 1'b0;
    int          cmp_k;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [46:0] r;
        r = {d, 7'd0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'b1000_1001;
        return r[6:0];
    endfunction

    function automatic logic [7:0] rsp_status(input logic [15:0] s, input logic [47:0] r);
        logic ok;
`ifdef SD_CMD_CRC_CHECK_EN
        ok = !s[7] || (r[7:1] == crc7(r[47:8]));
`else
        ok = 1'b1 || s[7] || r[0];
`endif
        return {2'b01, ok, 5'd0};
    endfunction

    // Per-cycle comparison of DUT outputs against the command model
    always @(negedge clk) begin
        if (active && !rst) begin
            cmp_k = cyc - tx_start;
            if (cyc < abort_cyc) begin
                if (cmp_k >= 0 && cmp_k <= 47) begin
                    check("tx_oe", cmd_oe, 1'b1);
                    check("tx_bit", cmd_o, tx_frame[47 - cmp_k]);
                    check("tx_ack_low", ack_out, 1'b0);
                    check("tx_busy", status, 8'h80);
                end else if (cmp_k >= 48 && cmp_k <= 48 + tx_delay) begin
                    check("dly_oe", cmd_oe, 1'b0);
                    check("dly_line", cmd_o, 1'b1);
                end
                if (cmp_k >= 0 && cyc < req_cyc) check("req_early", req_out, 1'b0);
                if (cyc == req_cyc) begin
                    check("req_rise", req_out, 1'b1);
                    check("status", status, exp_status);
                    if (chk_out) check("cmd_out", cmd_out, exp_out);
                end
            end else if (cyc == abort_cyc) begin
                check("abort_oe", cmd_oe, 1'b0);
                check("abort_ack", ack_out, 1'b1);
                check("abort_req", req_out, 1'b0);
                check("abort_status", status, 8'h00);
            end
        end
    end

    task automatic goto_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    // mode: 0 no response, 1 timeout, 2 short, 3 long, 4 abort mid-write
    task automatic run_cmd(input logic [39:0] c, input logic [15:0] s, input int mode,
                           input logic [135:0] rsp);
        int d, x, len, n;
        logic [47:0] r48;
        @(posedge clk); #1;
        d = int'(s[10:8]);
        len = 0;
        r48 = rsp[47:0];
        cmd_in = c;
        settings_in = s;
        tx_start = cyc + 4;
        tx_delay = d;
        tx_frame = {c, crc7(c), 1'b1};
        abort_cyc = 1 << 30;
        chk_out = 1'b0;
        x = tx_start + 48 + d;
        case (mode)
            0: begin req_cyc = tx_start + 49 + d; exp_status = 8'h60; end
            1: begin req_cyc = x + 65; exp_status = 8'h10; end
            2: begin len = 48; req_cyc = x + 4 + 48; exp_status = rsp_status(s, r48);
                     exp_out = r48[47:8]; chk_out = 1'b1; end
            3: begin len = 136; req_cyc = x + 4 + 136; exp_status = 8'h60;
                     exp_out = rsp[47:8]; chk_out = 1'b1; end
            default: req_cyc = 1 << 30;
        endcase
        req_in = 1'b1;
        active = 1'b1;
        n = 0;
        while (ack_out && n < 10) begin @(posedge clk); #1; n++; end
        check("ack_fall", ack_out, 1'b0);
        req_in = 1'b0;
        if (mode == 2 || mode == 3) begin
            goto_cyc(x + 3);
            for (int i = 0; i < len; i++) begin
                cmd_i = rsp[len - 1 - i];
                @(posedge clk); #1;
            end
            cmd_i = 1'b1;
        end
        if (mode == 4) begin
            goto_cyc(tx_start + 20);
            go_idle = 1'b1;
            abort_cyc = cyc + 1;
            @(posedge clk); #1;
            go_idle = 1'b0;
            check("abort_ack_main", ack_out, 1'b1);
            repeat (3) begin @(posedge clk); #1; end
            check("abort_stays_idle", cmd_oe, 1'b0);
        end else begin
            n = 0;
            while (!req_out && n < 400) begin @(posedge clk); #1; n++; end
            check("req_seen", req_out, 1'b1);
            ack_in = 1'b1;
            n = 0;
            while (req_out && n < 10) begin @(posedge clk); #1; n++; end
            check("req_drop", req_out, 1'b0);
            ack_in = 1'b0;
            n = 0;
            while (!ack_out && n < 10) begin @(posedge clk); #1; n++; end
            check("ack_return", ack_out, 1'b1);
        end
        active = 1'b0;
    endtask

    initial begin
        logic [135:0] long_rsp;
        rst = 1'b0; cmd_in = '0; settings_in = '0; req_in = 1'b0; ack_in = 1'b0;
        go_idle = 1'b0; cmd_i = 1'b1;
        #1 rst = 1'b1;
        #2;
        check("rst_req_out", req_out, 1'b0);
        check("rst_ack_out", ack_out, 1'b0);
        check("rst_cmd_out", cmd_out, 40'h0);
        check("rst_status", status, 8'h00);
        check("rst_cmd_o", cmd_o, 1'b1);
        check("rst_cmd_oe", cmd_oe, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("idle_ack_out", ack_out, 1'b1);

        // Hand-computed pins for the model
        check("pin_crc_cmd0", crc7(40'h4000000000), 7'h4A);
        check("pin_frame_cmd0", {40'h4000000000, crc7(40'h4000000000), 1'b1}, 48'h400000000095);
        check("pin_crc_r7", crc7(40'h08000001AA), 7'h09);
        check("pin_status_good", rsp_status(16'h02A8, 48'h08000001AA13), 8'h60);
`ifdef SD_CMD_CRC_CHECK_EN
        check("pin_status_bad", rsp_status(16'h02A8, 48'h08000001AA55), 8'h40);
`else
        check("pin_status_bad", rsp_status(16'h02A8, 48'h08000001AA55), 8'h60);
`endif

        run_cmd(40'h4000000000, 16'h0300, 0, '0);
        run_cmd(40'h48000001AA, 16'h02A8, 2, 136'h08000001AA13);
        run_cmd(40'h48000001AA, 16'h02A8, 2, 136'h08000001AA55);
        run_cmd(40'h48000001AA, 16'h0128, 1, '0);
        long_rsp = {8'h3F, 64'h0123456789ABCDEF, 64'hFEDCBA9876543211};
        run_cmd(40'h4200000000, 16'h00FF, 3, long_rsp);
        check("pin_long_out", exp_out, 40'h9876543211 >> 8 | 40'hBA00000000);
        run_cmd(40'h5100001000, 16'h0000, 4, '0);
        run_cmd(40'h5100001000, 16'h0428, 2, 136'h110000090055);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
